// File: rtl/hamming_scrub_ctrl_pkg.sv
// Shared types and helpers for the Hamming SECDED scrub controller.
package hamming_scrub_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    CHECK,
    WR_REQ,
    ADVANCE,
    GAP
  } scrub_state_e;

  // Number of Hamming check bits r such that 2^r >= data_width + r + 1.
  function automatic int hamming_address_width(input int data_width);
    int r;
    r = 1;
    while ((1 << r) < (data_width + r + 1)) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/hamming_decode.sv
// Combinational SECDED checker.
// Codeword layout: bit 0 is overall parity; bits 1..CODED_WIDTH-1 are Hamming
// positions with check bits at powers of two, so the syndrome is the index
// of a single flipped bit (0 when the overall parity bit itself flipped).
module hamming_decode
  import hamming_scrub_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  localparam int PAR_W = hamming_address_width(DATA_WIDTH),
  localparam int CODED_WIDTH = DATA_WIDTH + PAR_W + 1
) (
  input  logic [CODED_WIDTH-1:0] code_i,
  output logic [1:0]             num_errors_o,
  output logic [PAR_W-1:0]       location_o
);

  logic [PAR_W-1:0] syndrome;
  logic             parity_odd;

  // Syndrome and overall parity, then classify as clean / single / double.
  always_comb begin
    // NOTE: every output gets a default before any branch so no latch is inferred.
    syndrome     = '0;
    num_errors_o = 2'd0;
    location_o   = '0;
    for (int i = 1; i < CODED_WIDTH; i++) begin
      if (code_i[i]) syndrome = syndrome ^ PAR_W'(i);
    end
    parity_odd = ^code_i;
    if (parity_odd) begin
      if (int'(syndrome) < CODED_WIDTH) begin
        num_errors_o = 2'd1;
        location_o   = syndrome;
      end else begin
        // Odd parity pointing outside the word is not a single-bit error.
        num_errors_o = 2'd2;
      end
    end else if (syndrome != '0) begin
      num_errors_o = 2'd2;
    end
  end

endmodule

// File: rtl/hamming_scrub_ctrl.sv
// Background ECC scrubber: walks every address, checks each codeword and
// counts correctable / uncorrectable errors.
// Build option HAMMING_SCRUB_WRITEBACK_EN: when defined, single-bit errors are
// written back corrected; when undefined the scrub is report-only (mem_we = 0).
module hamming_scrub_ctrl
  import hamming_scrub_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int DEPTH          = 256,
  parameter int SCRUB_INTERVAL = 1024,
  parameter int CNT_W          = 16,
  localparam int PAR_W         = hamming_address_width(DATA_WIDTH),
  localparam int CODED_WIDTH   = DATA_WIDTH + PAR_W + 1,
  localparam int MEM_AW        = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   periodic_en,
  input  logic                   clear_counts,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [MEM_AW-1:0]      mem_addr,
  output logic [CODED_WIDTH-1:0] mem_wdata,
  input  logic                   mem_gnt,
  input  logic                   mem_rvalid,
  input  logic [CODED_WIDTH-1:0] mem_rdata,
  output logic                   busy,
  output logic                   sweep_done,
  output logic                   err_pulse,
  output logic [CNT_W-1:0]       corr_count,
  output logic [CNT_W-1:0]       uncorr_count,
  output logic [MEM_AW-1:0]      last_err_addr
);

  localparam logic [MEM_AW-1:0] LAST_ADDR = MEM_AW'(DEPTH - 1);
  localparam int                TMR_W     = (SCRUB_INTERVAL > 1) ? $clog2(SCRUB_INTERVAL) : 1;
  localparam logic [TMR_W-1:0]  GAP_LOAD  = TMR_W'(SCRUB_INTERVAL - 1);

  scrub_state_e           state_q, state_d;
  logic [MEM_AW-1:0]      addr_q, addr_d;
  logic [CODED_WIDTH-1:0] word_q, word_d;
  logic [CODED_WIDTH-1:0] wdata_q, wdata_d;
  logic [TMR_W-1:0]       gap_q, gap_d;
  logic                   periodic_q, periodic_d;
  logic [CNT_W-1:0]       corr_q, corr_d;
  logic [CNT_W-1:0]       uncorr_q, uncorr_d;
  logic [MEM_AW-1:0]      last_err_q, last_err_d;
  logic                   corr_inc, uncorr_inc;

  logic [1:0]             dec_num_errors;
  logic [PAR_W-1:0]       dec_location;

  hamming_decode #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_decode (
    .code_i      (word_q),
    .num_errors_o(dec_num_errors),
    .location_o  (dec_location)
  );

  // Next-state logic for the FSM, address pointer, gap timer and counters.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    word_d     = word_q;
    wdata_d    = wdata_q;
    gap_d      = gap_q;
    periodic_d = periodic_q;
    corr_d     = corr_q;
    uncorr_d   = uncorr_q;
    last_err_d = last_err_q;
    corr_inc   = 1'b0;
    uncorr_inc = 1'b0;

    unique case (state_q)
      IDLE: begin
        // A one-shot sweep always covers the whole memory from address 0.
        if (start) begin
          state_d    = RD_REQ;
          periodic_d = 1'b0;
          addr_d     = '0;
        end else if (periodic_en) begin
          state_d    = RD_REQ;
          periodic_d = 1'b1;
        end
      end
      RD_REQ: begin
        if (mem_gnt) state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (mem_rvalid) begin
          word_d  = mem_rdata;
          state_d = CHECK;
        end
      end
      CHECK: begin
        state_d = ADVANCE;
        if (dec_num_errors != 2'd0) last_err_d = addr_q;
        if (dec_num_errors == 2'd1) begin
          wdata_d = word_q ^ (CODED_WIDTH'(1) << dec_location);
`ifdef HAMMING_SCRUB_WRITEBACK_EN
          state_d = WR_REQ;
`else
          corr_inc = 1'b1;
`endif
        end else if (dec_num_errors == 2'd2) begin
          uncorr_inc = 1'b1;
        end
      end
      WR_REQ: begin
        if (mem_gnt) begin
          corr_inc = 1'b1;
          state_d  = ADVANCE;
        end
      end
      ADVANCE: begin
        addr_d = (addr_q == LAST_ADDR) ? '0 : addr_q + MEM_AW'(1);
        if (periodic_q) begin
          state_d = periodic_en ? GAP : IDLE;
          gap_d   = GAP_LOAD;
        end else begin
          state_d = (addr_q == LAST_ADDR) ? IDLE : RD_REQ;
        end
      end
      GAP: begin
        if (!periodic_en)       state_d = IDLE;
        else if (gap_q == '0)   state_d = RD_REQ;
        else                    gap_d   = gap_q - TMR_W'(1);
      end
      default: state_d = IDLE;
    endcase

    // Clearing takes priority over an increment in the same cycle.
    if (clear_counts)               corr_d = '0;
    else if (corr_inc && ~&corr_q)  corr_d = corr_q + CNT_W'(1);
    if (clear_counts)                 uncorr_d = '0;
    else if (uncorr_inc && ~&uncorr_q) uncorr_d = uncorr_q + CNT_W'(1);
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking (<=) so all registers update together.
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      word_q     <= '0;
      wdata_q    <= '0;
      gap_q      <= '0;
      periodic_q <= 1'b0;
      corr_q     <= '0;
      uncorr_q   <= '0;
      last_err_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      word_q     <= word_d;
      wdata_q    <= wdata_d;
      gap_q      <= gap_d;
      periodic_q <= periodic_d;
      corr_q     <= corr_d;
      uncorr_q   <= uncorr_d;
      last_err_q <= last_err_d;
    end
  end

  // Outputs decode straight from registered state, so reset drops mem_req at once.
  assign mem_req = (state_q == RD_REQ) || (state_q == WR_REQ);
`ifdef HAMMING_SCRUB_WRITEBACK_EN
  assign mem_we  = (state_q == WR_REQ);
`else
  assign mem_we  = 1'b0;
`endif
  assign mem_addr      = addr_q;
  assign mem_wdata     = wdata_q;
  assign busy          = (state_q != IDLE) && (state_q != GAP);
  assign sweep_done    = (state_q == ADVANCE) && (addr_q == LAST_ADDR);
  assign err_pulse     = (state_q == CHECK) && (dec_num_errors == 2'd2);
  assign corr_count    = corr_q;
  assign uncorr_count  = uncorr_q;
  assign last_err_addr = last_err_q;

endmodule

// File: tb/tb_hamming_scrub_ctrl.sv
// Scoreboard bench for hamming_scrub_ctrl: a memory model answers requests,
// stimulus pushes expected memory transactions, a monitor pops and compares.
module tb_hamming_scrub_ctrl;

  localparam int DW       = 32;
  localparam int DEPTH    = 8;
  localparam int INTERVAL = 4;
  localparam int CNT_W    = 2;
  localparam int CW       = 39;
  localparam int AW       = 3;
`ifdef HAMMING_SCRUB_WRITEBACK_EN
  localparam bit WB = 1'b1;
`else
  localparam bit WB = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0;
  logic start = 1'b0, periodic_en = 1'b0, clear_counts = 1'b0;
  logic mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [CW-1:0] mem_wdata;
  logic mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic [CW-1:0] mem_rdata = '0;
  logic busy, sweep_done, err_pulse;
  logic [CNT_W-1:0] corr_count, uncorr_count;
  logic [AW-1:0] last_err_addr;

  hamming_scrub_ctrl #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .SCRUB_INTERVAL(INTERVAL), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .periodic_en(periodic_en),
    .clear_counts(clear_counts), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .busy(busy),
    .sweep_done(sweep_done), .err_pulse(err_pulse), .corr_count(corr_count),
    .uncorr_count(uncorr_count), .last_err_addr(last_err_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [CW-1:0] wdata;
  } txn_t;

  txn_t          exp_q[$];
  txn_t          mon_t;
  int            total = 0, bad = 0;
  logic [CW-1:0] mem[DEPTH];
  logic [CW-1:0] golden[DEPTH];
  int            kind[DEPTH];   // 0 clean, 1 single-bit error, 2 double-bit error
  int            cycle = 0;
  int            hs_cycles[$];
  int            n_rd = 0, n_wr = 0, n_sweep = 0, n_err = 0;
  int            stall_all = 0;
  bit            stall_wr = 1'b0, inject_rv = 1'b0;
  bit            hs_v = 1'b0, hs_we = 1'b0;
  logic [AW-1:0] hs_addr;
  logic [CW-1:0] hs_wdata;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference SECDED encoder: bit 0 overall parity, check bits at powers of two.
  function automatic logic [CW-1:0] encode(input logic [DW-1:0] d);
    logic [CW-1:0] c;
    logic x;
    int j;
    c = '0;
    j = 0;
    for (int p = 1; p < CW; p++) begin
      if ((p & (p - 1)) != 0) begin
        c[p] = d[j];
        j++;
      end
    end
    for (int k = 0; k < 6; k++) begin
      x = 1'b0;
      for (int p = 1; p < CW; p++)
        if ((((p >> k) & 1) == 1) && ((p & (p - 1)) != 0)) x = x ^ c[p];
      c[1 << k] = x;
    end
    c[0] = ^c[CW-1:1];
    return c;
  endfunction

  // Memory model: grants at the negedge, returns read data one cycle after grant.
  always @(negedge clk) begin
    cycle++;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    if (hs_v && rst_n) begin
      if (hs_we) mem[hs_addr] = hs_wdata;
      else begin
        mem_rvalid = 1'b1;
        mem_rdata  = mem[hs_addr];
      end
    end
    hs_v = 1'b0;
    if (inject_rv && !mem_rvalid) begin
      mem_rvalid = 1'b1;
      mem_rdata  = golden[0] ^ 39'h10;
    end
    if (mem_req && stall_all == 0 && !(stall_wr && mem_we)) begin
      mem_gnt  = 1'b1;
      hs_v     = 1'b1;
      hs_we    = mem_we;
      hs_addr  = mem_addr;
      hs_wdata = mem_wdata;
    end else begin
      mem_gnt = 1'b0;
      if (stall_all > 0 && mem_req) stall_all--;
    end
  end

  // Monitor: counts pulses and scores every granted memory transaction.
  always @(negedge clk) begin
    #1;
    if (sweep_done) n_sweep++;
    if (err_pulse) n_err++;
    if (mem_req && mem_gnt) begin
      hs_cycles.push_back(cycle);
      if (mem_we) n_wr++; else n_rd++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_txn: got we=%0b addr=%0d, none expected", mem_we, mem_addr);
      end else begin
        mon_t = exp_q.pop_front();
        check("txn_we", 64'(mem_we), 64'(mon_t.we));
        check("txn_addr", 64'(mem_addr), 64'(mon_t.addr));
        if (mon_t.we) check("txn_wdata", 64'(mem_wdata), 64'(mon_t.wdata));
      end
    end
  end

  // Push the expected transactions for `count` words starting at `first`.
  task automatic plan(input int first, input int count);
    txn_t t;
    int a;
    for (int i = 0; i < count; i++) begin
      a = (first + i) % DEPTH;
      t.we = 1'b0; t.addr = AW'(a); t.wdata = '0;
      exp_q.push_back(t);
      if (WB && kind[a] == 1) begin
        t.we = 1'b1; t.wdata = golden[a];
        exp_q.push_back(t);
      end
    end
  endtask

  task automatic restore();
    for (int a = 0; a < DEPTH; a++) begin
      mem[a]  = golden[a];
      kind[a] = 0;
    end
  endtask

  task automatic zero_stats();
    n_rd = 0; n_wr = 0; n_sweep = 0; n_err = 0;
    hs_cycles.delete();
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_busy_falls"}, 64'(busy), 64'(0));
    check({name, "_queue_empty"}, 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [CW-1:0] planted;
    bit stable;
    int n;

    for (int a = 0; a < DEPTH; a++) begin
      golden[a] = encode(32'hA5C3_0F10 + 32'h1357_9BDF * 32'(a));
    end
    restore();

    // Reset state.
    #12;
    check("rst_mem_req", 64'(mem_req), 64'(0));
    check("rst_mem_we", 64'(mem_we), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_addr", 64'(mem_addr), 64'(0));
    check("rst_counts", 64'({corr_count, uncorr_count}), 64'(0));
    check("rst_pulses", 64'({sweep_done, err_pulse}), 64'(0));
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // 1: clean sweep.
    zero_stats(); plan(0, 8); pulse_start(); wait_idle("t1");
    check("t1_reads", 64'(n_rd), 64'(8));
    check("t1_writes", 64'(n_wr), 64'(0));
    check("t1_sweep_done", 64'(n_sweep), 64'(1));
    check("t1_counts", 64'({corr_count, uncorr_count}), 64'(0));
    check("t1_addr_wrap", 64'(mem_addr), 64'(0));

    // 2: single-bit error at addr 3, bit 5.
    planted = golden[3] ^ (39'h1 << 5);
    mem[3] = planted; kind[3] = 1;
    zero_stats(); plan(0, 8); pulse_start(); wait_idle("t2");
    check("t2_writes", 64'(n_wr), WB ? 64'(1) : 64'(0));
    check("t2_corr", 64'(corr_count), 64'(1));
    check("t2_uncorr", 64'(uncorr_count), 64'(0));
    check("t2_last_err", 64'(last_err_addr), 64'(3));
    check("t2_mem3", 64'(mem[3]), WB ? 64'(golden[3]) : 64'(planted));
    restore();

    // 3: double-bit error at addr 6, bits 2 and 9.
    planted = golden[6] ^ (39'h1 << 2) ^ (39'h1 << 9);
    mem[6] = planted; kind[6] = 2;
    zero_stats(); plan(0, 8); pulse_start(); wait_idle("t3");
    check("t3_err_pulse", 64'(n_err), 64'(1));
    check("t3_uncorr", 64'(uncorr_count), 64'(1));
    check("t3_writes", 64'(n_wr), 64'(0));
    check("t3_mem6", 64'(mem[6]), 64'(planted));
    check("t3_last_err", 64'(last_err_addr), 64'(6));
    @(negedge clk); clear_counts = 1'b1;
    @(negedge clk); clear_counts = 1'b0;
    check("t3_cleared", 64'({corr_count, uncorr_count}), 64'(0));
    restore();

    // 4: grant withheld 20 cycles with stray rvalid while requesting.
    zero_stats(); plan(0, 8);
    stall_all = 20; inject_rv = 1'b1;
    pulse_start();
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (!(mem_req === 1'b1 && mem_addr === '0 && mem_we === 1'b0)) stable = 1'b0;
      @(negedge clk);
    end
    inject_rv = 1'b0;
    check("t4_req_stable", 64'(stable), 64'(1));
    wait_idle("t4");
    check("t4_reads", 64'(n_rd), 64'(8));
    check("t4_counts", 64'({corr_count, uncorr_count}), 64'(0));
    check("t4_err_pulse", 64'(n_err), 64'(0));

    // 5: periodic mode, 4-cycle gap, wrap 7 -> 0.
    zero_stats(); plan(0, 9);
    @(negedge clk); periodic_en = 1'b1;
    n = 0;
    while (n_rd < 9 && n < 400) begin
      @(negedge clk); #2;
      n++;
    end
    periodic_en = 1'b0;
    check("t5_reads", 64'(n_rd), 64'(9));
    wait_idle("t5");
    check("t5_sweep_done", 64'(n_sweep), 64'(1));
    for (int i = 1; i < hs_cycles.size(); i++)
      check("t5_read_spacing", 64'(hs_cycles[i] - hs_cycles[i-1]), 64'(8));
    check("t5_addr_kept", 64'(mem_addr), 64'(1));
    repeat (12) @(negedge clk);
    check("t5_stopped", 64'(n_rd), 64'(9));

    // Clear held through a sweep with errors: every increment loses to clear.
    mem[1] = golden[1] ^ (39'h1 << 17); kind[1] = 1;
    mem[2] = golden[2] ^ 39'h3;         kind[2] = 2;
    zero_stats(); plan(0, 8);
    clear_counts = 1'b1;
    pulse_start(); wait_idle("t6");
    clear_counts = 1'b0;
    check("t6_clear_wins", 64'({corr_count, uncorr_count}), 64'(0));
    check("t6_err_pulse", 64'(n_err), 64'(1));
    restore();

    // Saturation: four of each error kind into 2-bit counters.
    for (int a = 0; a < DEPTH; a++) begin
      if (a == 0 || a == 1 || a == 4 || a == 5) begin
        mem[a] = golden[a] ^ (39'h1 << 3) ^ (39'h1 << 30); kind[a] = 2;
      end else begin
        mem[a] = golden[a] ^ (39'h1 << (a + 10)); kind[a] = 1;
      end
    end
    zero_stats(); plan(0, 8); pulse_start(); wait_idle("t7");
    check("t7_corr_sat", 64'(corr_count), 64'(3));
    check("t7_uncorr_sat", 64'(uncorr_count), 64'(3));
    check("t7_err_pulse", 64'(n_err), 64'(4));
    check("t7_last_err", 64'(last_err_addr), 64'(7));
    check("t7_writes", 64'(n_wr), WB ? 64'(4) : 64'(0));
    restore();

    // 6: reset while a write-back (or, report-only, a read) waits for grant.
    if (WB) begin
      mem[2] = golden[2] ^ (39'h1 << 12); kind[2] = 1;
      stall_wr = 1'b1;
    end else begin
      stall_all = 1000;
    end
    zero_stats(); plan(0, 8); pulse_start();
    n = 0;
    while (!(mem_req && (mem_we == WB)) && n < 200) begin
      @(negedge clk); #2;
      n++;
    end
    check("t8_reached_req", 64'(mem_req && (mem_we == WB)), 64'(1));
    #1 rst_n = 1'b0;
    #1;
    check("t8_req_drops_async", 64'(mem_req), 64'(0));
    repeat (2) @(negedge clk);
    stall_wr = 1'b0; stall_all = 0;
    exp_q.delete();
    rst_n = 1'b1;
    @(negedge clk); #1;
    check("t8_idle", 64'({busy, mem_req}), 64'(0));
    check("t8_counts", 64'({corr_count, uncorr_count}), 64'(0));
    check("t8_addr", 64'(mem_addr), 64'(0));
    check("t8_last_err", 64'(last_err_addr), 64'(0));
    restore();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
